// File: rtl/op_n_to_2_pipe.sv
// Pipelined carry-save reduction of OP_NUM operands down to a sum/carry pair.
// Layers of 3:2 compressors, a registered slice every REG_EVERY layers, valid/ready flow control.
module op_n_to_2_pipe #(
  parameter int OP_NUM    = 16,
  parameter int OP_WIDTH  = 64,
  parameter int REG_EVERY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_op [OP_NUM],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_op [2],
  output logic [OP_WIDTH-1:0] sum
);

  function automatic int next_n(input int n);
    return (n % 3) + 2 * (n / 3);
  endfunction

  function automatic int n_at(input int k);
    int n;
    n = OP_NUM;
    for (int i = 0; i < k; i++) n = next_n(n);
    return n;
  endfunction

  function automatic int count_layers(input int n0);
    int n;
    int s;
    n = n0;
    s = 0;
    while (n > 2) begin
      n = next_n(n);
      s++;
    end
    return s;
  endfunction

  localparam int S = count_layers(OP_NUM);
  localparam int L = (S + REG_EVERY - 1) / REG_EVERY;

  // stg[k] holds the operands entering layer k; entries past the live count are tied to zero.
  logic [OP_WIDTH-1:0] stg [S+1][OP_NUM];
  logic [L-1:0]        v_q, v_d;
  logic [L:0]          rdy;

  assign stg[0] = in_op;

  for (genvar k = 0; k < S; k++) begin : g_layer
    localparam int N  = n_at(k);
    localparam int R  = N % 3;
    localparam int G  = N / 3;
    localparam int NO = R + 2 * G;

    logic [OP_WIDTH-1:0] lay_d [NO];

    for (genvar i = 0; i < R; i++) begin : g_pass
      assign lay_d[i] = stg[k][i];
    end

    for (genvar j = 0; j < G; j++) begin : g_csa
      logic [OP_WIDTH-1:0] op_a, op_b, op_c;
      assign op_a = stg[k][R+3*j];
      assign op_b = stg[k][R+3*j+1];
      assign op_c = stg[k][R+3*j+2];
      assign lay_d[R+2*j]   = op_a ^ op_b ^ op_c;
      assign lay_d[R+2*j+1] = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;
    end

    if (((k + 1) % REG_EVERY == 0) || (k == S - 1)) begin : g_reg
      localparam int SL = k / REG_EVERY;
      logic [OP_WIDTH-1:0] lay_q [NO];

      // Data follows the slice ready even when the upstream beat is invalid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NO; i++) lay_q[i] <= '0;
        end else if (rdy[SL]) begin
          lay_q <= lay_d;
        end
      end

      for (genvar i = 0; i < NO; i++) begin : g_out
        assign stg[k+1][i] = lay_q[i];
      end
    end else begin : g_comb
      for (genvar i = 0; i < NO; i++) begin : g_out
        assign stg[k+1][i] = lay_d[i];
      end
    end

    for (genvar i = NO; i < OP_NUM; i++) begin : g_pad
      assign stg[k+1][i] = '0;
    end
  end

  always_comb begin
    rdy    = '0;
    rdy[L] = out_ready;
    for (int s = L - 1; s >= 0; s--) rdy[s] = !v_q[s] | rdy[s+1];

    v_d    = v_q;
    v_d[0] = rdy[0] ? in_valid : v_q[0];
    for (int s = 1; s < L; s++) v_d[s] = rdy[s] ? v_q[s-1] : v_q[s];
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[L-1];
  assign out_op[0] = stg[S][0];
  assign out_op[1] = stg[S][1];
  assign sum       = stg[S][0] + stg[S][1];

endmodule

// File: doc/op_n_to_2_pipe.md
# op_n_to_2_pipe

Pipelined, flow-controlled carry-save reduction tree for the Booth-4 Wallace multiplier datapath. It compresses `OP_NUM` partial-product operands of `OP_WIDTH` bits into a sum/carry pair using layers of 3:2 compressors. Pipeline registers are inserted every `REG_EVERY` compressor layers. A valid/ready handshake lets it sit between the Booth encoder and the final carry-propagate adder under backpressure.

## Interface
- `OP_NUM`, 16: number of input operands; legal range is ≥3.
- `OP_WIDTH`, 64: operand width; all arithmetic is modulo 2^OP_WIDTH.
- `REG_EVERY`, 2: number of compressor layers per pipeline slice; legal range is ≥1.
- `clk` input, 1: clock; all state is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `flush` input, 1: synchronous; clears every slice valid bit.
- `in_valid` input, 1: `in_op` holds a valid operand set.
- `in_ready` output, 1: the block accepts `in_op` this cycle.
- `in_op` input, `[OP_WIDTH-1:0] x OP_NUM`: operands to reduce.
- `out_valid` output, 1: `out_op` and `sum` are valid.
- `out_ready` input, 1: downstream consumes the output this cycle.
- `out_op` output, `[OP_WIDTH-1:0] x 2`: carry-save result pair.
- `sum` output, `OP_WIDTH`: equals `out_op[0] + out_op[1]` (mod 2^OP_WIDTH), formed combinationally from the output registers.

## Operation
- **Layer count S.** Start with n0 = OP_NUM. Each layer computes n_{k+1} = n_k % 3 + 2*(n_k / 3). Iterate until n = 2. S is the number of iterations.
  - OP_NUM=16 gives 16→11→8→6→4→3→2, so S=6.
  - OP_NUM=3 gives S=1.
- **Layer k contents** (n = n_k inputs, r = n % 3):
  - Inputs [0..r-1] pass unchanged to outputs [0..r-1].
  - Group j uses inputs a,b,c = [r+3j], [r+3j+1], [r+3j+2].
  - Group j drives output [r+2j] = a^b^c.
  - Group j drives output [r+2j+1] = ((a&b)|(a&c)|(b&c)) << 1, truncated to OP_WIDTH.
- **Invariant.** At every layer, the sum of all operands mod 2^OP_WIDTH equals the sum of the inputs mod 2^OP_WIDTH.
- **Slicing.**
  - A register bank with a valid bit v_s follows layer k when (k+1) % REG_EVERY == 0, and always follows the last layer.
  - Slice count L = ceil(S/REG_EVERY). Slices are numbered 0..L-1; slice L-1 drives `out_op`/`out_valid`.
- **Flow control** (per slice s, with slice L-1's downstream being the output port):
  - ready_s = !v_s | ready_{s+1}.
  - ready_L = out_ready.
  - `in_ready` = ready_0.
  - Slice s loads when ready_s is high. It loads data from its upstream and sets v_s to the upstream valid (`in_valid` for slice 0).
  - When ready_s is low, slice s holds data and valid unchanged.
  - Data registers may load on any ready_s cycle, valid or not. Outputs are don't-care while `out_valid`=0.
- **Stall behaviour.**
  - Full pipeline with `out_ready`=0: all v_s=1, `in_ready`=0, and no data changes.
  - Bubbles collapse. An empty slice accepts even when downstream is stalled.
- **Flush.**
  - `flush`=1 sets all v_s to 0 at the next edge. It takes priority over loads.
  - `in_ready` is unaffected, so an operand presented with `in_valid` during flush is dropped.
- **Reset.**
  - All v_s=0, `out_valid`=0, and `out_op`=0, so `sum`=0.
  - `in_ready`=1 during and after reset.
  - Reset mid-operation discards all in-flight data.
- `out_valid` is never combinationally dependent on `in_valid`.

## Timing
- Latency: an operand set accepted at edge t appears at `out_op` after edge t+L-1, i.e. `out_valid` is high in the cycle following edge t+L-1.
  - OP_NUM=16, REG_EVERY=2: L=3.
  - OP_NUM=16, REG_EVERY=1: L=6.
  - REG_EVERY ≥ S: L=1.
- Throughput: one operand set per cycle while `out_ready`=1.
- The ordering of results is FIFO with respect to accepted inputs. No result is ever duplicated or dropped, except by flush or reset.
- Combinational path: the `out_ready`→`in_ready` chain spans L AND-OR levels. No register is placed on ready.
- The critical data path is REG_EVERY compressor layers (a 3-input majority and an XOR per layer).

## Test plan
- **Basic sum.** OP_NUM=16, OP_WIDTH=64, REG_EVERY=2; in_op[i]=i+1, in_valid pulse, out_ready=1 → out_valid high 3 cycles after acceptance; sum=136; out_op[0]+out_op[1]=136.
- **Wrap-around.** All 16 operands = 64'hFFFF_FFFF_FFFF_FFFF → sum=64'hFFFF_FFFF_FFFF_FFF0, i.e. -16 mod 2^64.
- **Streaming.** 100 random operand sets streamed back-to-back with random out_ready (50% duty) → every output matches a reference modulo sum, in order, with none lost. in_ready=0 exactly when the pipeline is full and out_ready=0.
- **Backpressure.** out_ready held 0 for 10 cycles while feeding → exactly L=3 sets accepted, then in_ready=0; outputs stable. Releasing out_ready drains the 3 sets in order in 3 cycles.
- **Flush and reset.** Flush with 2 sets in flight → out_valid=0 the next cycle and neither set ever appears. rst_n low mid-stream → out_valid=0, out_op=0, in_ready=1 immediately.
- **Parameter sweep.** OP_NUM∈{3,4,7,16,33}, REG_EVERY∈{1,2,7} → measured latency equals ceil(S/REG_EVERY), and the sum is correct for random operands.
